// File: rtl/lsu.sv
// lsu: RV64 load/store unit running a req/ack data-memory transaction
// and returning an aligned, sign/zero-extended load value.
module lsu (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [63:0] rdata_o,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wmask_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [2:0]  f3_q, off_q;
    logic        we_q, err_q;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [7:0]  mask_q;
    logic        accept, misalign, bad;
    logic [1:0]  sz;
    logic [7:0]  base;
    logic [63:0] sh, ext;
    always_comb begin
        accept   = (state == IDLE) & valid_i & (mem_read_i | mem_write_i);
        sz       = funct3_i[1:0];
        misalign = (sz == 2'd1) ? addr_i[0] : (sz == 2'd2) ? |addr_i[1:0] : (sz == 2'd3) ? |addr_i[2:0] : 1'b0;
        bad      = (mem_read_i & mem_write_i) | (mem_write_i ? funct3_i[2] : funct3_i == 3'b111) | misalign;
        base     = (sz == 2'd0) ? 8'h01 : (sz == 2'd1) ? 8'h03 : (sz == 2'd2) ? 8'h0f : 8'hff;
        sh       = dmem_rdata_i >> {off_q, 3'b000};
        // funct3[2] set means unsigned: suppress the sign fill
        ext      = (f3_q[1:0] == 2'd0) ? {{56{~f3_q[2] & sh[7]}}, sh[7:0]} :
                   (f3_q[1:0] == 2'd1) ? {{48{~f3_q[2] & sh[15]}}, sh[15:0]} :
                   (f3_q[1:0] == 2'd2) ? {{32{~f3_q[2] & sh[31]}}, sh[31:0]} : sh;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            f3_q    <= funct3_i;
            off_q   <= addr_i[2:0];
            addr_q  <= {addr_i[63:3], 3'b000};
            we_q    <= mem_write_i;
            wdata_q <= wdata_i << {addr_i[2:0], 3'b000};
            mask_q  <= mem_write_i ? base << addr_i[2:0] : 8'h00;
            err_q   <= bad;
            rdata_q <= bad ? 64'd0 : rdata_q;
            state   <= bad ? DONE : REQ;
        end else if (state == REQ && dmem_ack_i) begin
            rdata_q <= we_q ? 64'd0 : ext;
            state   <= DONE;
        end else if (state[1]) begin
            state   <= IDLE;
        end
    end
    assign stall_o      = accept | (state == REQ);
    assign done_o       = state == DONE;
    assign err_o        = done_o & err_q;
    assign rdata_o      = rdata_q;
    assign dmem_req_o   = state == REQ;
    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_wmask_o = mask_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed-vector bench for the load/store unit.
module tb_lsu;
    logic        clk = 0, rstn = 0, valid_i = 0, mem_read_i = 0, mem_write_i = 0, dmem_ack_i = 0;
    logic [2:0]  funct3_i = 0;
    logic [63:0] addr_i = 0, wdata_i = 0, dmem_rdata_i = 0;
    logic        stall_o, done_o, err_o, dmem_req_o, dmem_we_o;
    logic [63:0] rdata_o, dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wmask_o;
    int          checks = 0, errors = 0;
    logic [63:0] mem_word = 0;
    int          o_stalls, o_done_at, o_reqs;
    logic        o_err, o_we, o_stable, o_first_stall;
    logic [63:0] o_rd, o_addr, o_wdata;
    logic [7:0]  o_mask;

    lsu dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    // Drives one instruction from the current IDLE cycle and records what the DUT did;
    // returns one cycle after DONE. Ack is given on REQ cycle number waits+1.
    task automatic do_access(input logic r, input logic w, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input int waits, input logic [63:0] rd);
        valid_i = 1; mem_read_i = r; mem_write_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
        o_stalls = 0; o_done_at = -1; o_reqs = 0; o_stable = 1; o_rd = '0; o_err = 0;
        o_addr = '0; o_we = 0; o_mask = '0; o_wdata = '0; o_first_stall = 0;
        for (int c = 0; c < 50 && o_done_at < 0; c++) begin
            #1;
            if (c == 0) o_first_stall = stall_o;
            if (stall_o) o_stalls++;
            if (dmem_req_o) begin
                if (o_reqs == 0) begin
                    o_addr = dmem_addr_o; o_we = dmem_we_o; o_mask = dmem_wmask_o; o_wdata = dmem_wdata_o;
                end else if ({dmem_addr_o, dmem_we_o, dmem_wmask_o, dmem_wdata_o} !== {o_addr, o_we, o_mask, o_wdata}) begin
                    o_stable = 0;
                end
                o_reqs++;
                if (o_reqs > waits) begin
                    dmem_ack_i = 1;
                    dmem_rdata_i = rd;
                    if (dmem_we_o)
                        for (int k = 0; k < 8; k++)
                            if (dmem_wmask_o[k]) mem_word[8*k +: 8] = dmem_wdata_o[8*k +: 8];
                end
            end
            if (done_o) begin o_done_at = c; o_rd = rdata_o; o_err = err_o; end
            @(posedge clk); #1;
            valid_i = 0; mem_read_i = 0; mem_write_i = 0; dmem_ack_i = 0;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({stall_o, done_o, err_o, dmem_req_o, dmem_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {stall_o, done_o, err_o, dmem_req_o, dmem_we_o}); end
        checks++; if ({rdata_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%h/%h exp 0", rdata_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o); end
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_lb;
        do_access(1, 0, 3'b000, 64'h1003, 64'h0, 2, 64'h0000_0000_80FF_0000);
        checks++; if (o_addr !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h exp 1000", o_addr); end
        checks++; if (o_stalls != 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d exp 4", o_stalls); end
        checks++; if (o_done_at != 4) begin errors++; $display("FAIL lb_done_cycle: got %0d exp 4", o_done_at); end
        checks++; if (o_rd !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h exp ffffffffffffff80", o_rd); end
        checks++; if ({o_err, o_we, o_mask} !== 10'b0) begin errors++; $display("FAIL lb_err_we_mask: got %b/%b/%h exp 0/0/00", o_err, o_we, o_mask); end
        #1;
        checks++; if (rdata_o !== 64'hFFFF_FFFF_FFFF_FF80 || done_o !== 1'b0) begin errors++; $display("FAIL lb_hold: got %h done %b exp ffffffffffffff80 done 0", rdata_o, done_o); end
    endtask

    task automatic test_lw;
        do_access(1, 0, 3'b110, 64'h2004, 64'h0, 0, 64'h8765_4321_0000_0000);
        checks++; if (o_done_at != 2) begin errors++; $display("FAIL lwu_done_cycle: got %0d exp 2", o_done_at); end
        checks++; if (o_rd !== 64'h0000_0000_8765_4321) begin errors++; $display("FAIL lwu_rdata: got %h exp 0000000087654321", o_rd); end
        do_access(1, 0, 3'b010, 64'h2004, 64'h0, 0, 64'h8765_4321_0000_0000);
        checks++; if (o_rd !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_rdata: got %h exp ffffffff87654321", o_rd); end
        do_access(1, 0, 3'b101, 64'h2002, 64'h0, 1, 64'h0000_0000_9ABC_0000);
        checks++; if (o_rd !== 64'h0000_0000_0000_9ABC) begin errors++; $display("FAIL lhu_rdata: got %h exp 0000000000009abc", o_rd); end
    endtask

    task automatic test_misaligned;
        do_access(0, 1, 3'b010, 64'h4002, 64'h55, 0, 64'h0);
        checks++; if (o_reqs != 0) begin errors++; $display("FAIL sw_mis_req: got %0d req cycles exp 0", o_reqs); end
        checks++; if (o_done_at != 1 || o_err !== 1'b1) begin errors++; $display("FAIL sw_mis_done: got cycle %0d err %b exp cycle 1 err 1", o_done_at, o_err); end
        checks++; if (o_stalls != 1) begin errors++; $display("FAIL sw_mis_stall: got %0d exp 1", o_stalls); end
        checks++; if (o_rd !== 64'h0) begin errors++; $display("FAIL sw_mis_rdata: got %h exp 0", o_rd); end
        do_access(1, 0, 3'b011, 64'h5004, 64'h0, 0, 64'h0);
        checks++; if (o_err !== 1'b1 || o_reqs != 0) begin errors++; $display("FAIL ld_mis: got err %b reqs %0d exp err 1 reqs 0", o_err, o_reqs); end
        do_access(1, 0, 3'b001, 64'h11, 64'h0, 0, 64'h0);
        checks++; if (o_err !== 1'b1 || o_reqs != 0) begin errors++; $display("FAIL lh_mis: got err %b reqs %0d exp err 1 reqs 0", o_err, o_reqs); end
        do_access(1, 0, 3'b111, 64'h0, 64'h0, 0, 64'h0);
        checks++; if (o_err !== 1'b1 || o_reqs != 0) begin errors++; $display("FAIL load_f3_illegal: got err %b reqs %0d exp err 1 reqs 0", o_err, o_reqs); end
        do_access(0, 1, 3'b100, 64'h0, 64'h0, 0, 64'h0);
        checks++; if (o_err !== 1'b1 || o_reqs != 0) begin errors++; $display("FAIL store_f3_illegal: got err %b reqs %0d exp err 1 reqs 0", o_err, o_reqs); end
        do_access(1, 1, 3'b000, 64'h0, 64'h0, 0, 64'h0);
        checks++; if (o_err !== 1'b1 || o_reqs != 0) begin errors++; $display("FAIL rd_wr_both: got err %b reqs %0d exp err 1 reqs 0", o_err, o_reqs); end
        do_access(1, 0, 3'b000, 64'h7, 64'h0, 0, 64'h0100_0000_0000_0000);
        checks++; if (o_err !== 1'b0 || o_rd !== 64'h1) begin errors++; $display("FAIL lb_top_lane: got err %b rdata %h exp err 0 rdata 1", o_err, o_rd); end
    endtask

    task automatic test_sh;
        do_access(0, 1, 3'b001, 64'h3006, 64'h1234, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (o_we !== 1'b1 || o_mask !== 8'hC0) begin errors++; $display("FAIL sh_we_mask: got %b/%h exp 1/c0", o_we, o_mask); end
        checks++; if (o_wdata !== 64'h1234_0000_0000_0000 || o_addr !== 64'h3000) begin errors++; $display("FAIL sh_wdata_addr: got %h/%h exp 1234000000000000/3000", o_wdata, o_addr); end
        checks++; if (o_stable !== 1'b1 || o_reqs != 3) begin errors++; $display("FAIL sh_req_stable: got stable %b reqs %0d exp 1/3", o_stable, o_reqs); end
        checks++; if (o_done_at != 4 || o_rd !== 64'h0 || o_err !== 1'b0) begin errors++; $display("FAIL sh_done: got cycle %0d rdata %h err %b exp 4/0/0", o_done_at, o_rd, o_err); end
    endtask

    task automatic test_abandon;
        valid_i = 1; mem_read_i = 1; funct3_i = 3'b011; addr_i = 64'h6000;
        @(posedge clk); #1;
        valid_i = 0; mem_read_i = 0;
        checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL abandon_req_before: got %b exp 1", dmem_req_o); end
        #1 rstn = 0;
        #1;
        checks++; if ({dmem_req_o, done_o, err_o, stall_o} !== 4'b0) begin errors++; $display("FAIL abandon_async: got %b exp 0000", {dmem_req_o, done_o, err_o, stall_o}); end
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        dmem_ack_i = 1; dmem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({done_o, dmem_req_o, err_o} !== 3'b0) begin errors++; $display("FAIL abandon_late_ack%0d: got %b exp 000", c, {done_o, dmem_req_o, err_o}); end
            @(posedge clk); #1;
            dmem_ack_i = 0;
        end
        checks++; if (rdata_o !== 64'h0) begin errors++; $display("FAIL abandon_rdata: got %h exp 0", rdata_o); end
    endtask

    task automatic test_back_to_back;
        mem_word = 64'h0;
        do_access(0, 1, 3'b011, 64'h5000, 64'hDEAD_BEEF_0123_4567, 0, 64'h0);
        checks++; if (o_done_at != 2 || o_mask !== 8'hFF) begin errors++; $display("FAIL b2b_sd: got cycle %0d mask %h exp 2/ff", o_done_at, o_mask); end
        do_access(1, 0, 3'b011, 64'h5000, 64'h0, 0, mem_word);
        checks++; if (o_first_stall !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b exp 1", o_first_stall); end
        checks++; if (o_done_at != 2 || o_rd !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL b2b_ld: got cycle %0d rdata %h exp 2/deadbeef01234567", o_done_at, o_rd); end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lw;
        test_misaligned;
        test_sh;
        test_abandon;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV64 scpu datapath. It sits directly downstream of the ALU: it takes the ALU result as the effective address and rs2 as store data. It then runs a multi-cycle request/acknowledge transaction on the data-memory port and returns an aligned, sign/zero-extended load value to writeback. The pipeline is held on `stall_o` until the access completes.

## Interface
- No parameters; data path fixed at 64 bits, 8-byte memory words.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `valid_i` in 1: the current instruction is valid.
- `mem_read_i` in 1: the instruction is a load.
- `mem_write_i` in 1: the instruction is a store.
- `funct3_i` in 3: access size and extension, inst[14:12].
- `addr_i` in 64: effective address (ALU `res`).
- `wdata_i` in 64: store data (rs2).
- `stall_o` out 1: hold PC and instruction; comb.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out 64: extended load result; valid when `done_o`=1.
- `err_o` out 1: misaligned or illegal access; pulses with `done_o`.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = write.
- `dmem_addr_o` out 64: `addr_i` with [2:0] forced to 0.
- `dmem_wdata_o` out 64: store data shifted into its byte lanes.
- `dmem_wmask_o` out 8: byte-lane write enables.
- `dmem_ack_i` in 1: memory completion; sampled only while `dmem_req_o`=1.
- `dmem_rdata_i` in 64: read word; valid in the same cycle as `dmem_ack_i`.

## Operation
- States: IDLE, REQ, DONE. Reset enters IDLE.
- **IDLE**
  - Accept when `valid_i` & (`mem_read_i` | `mem_write_i`).
  - Latch funct3, addr, wdata and direction.
  - If the access is legal, go to REQ. Otherwise go to DONE with the error flag set and no memory request.
- **REQ**
  - `dmem_req_o`=1. Address, `we`, wdata and mask come from registers and stay stable until ack.
  - On `dmem_ack_i`=1: capture read data and go to DONE. Otherwise stay in REQ with no timeout.
- **DONE**
  - `done_o`=1 and `stall_o`=0, so the pipeline advances this cycle.
  - Inputs are ignored, so the same instruction is never re-accepted.
  - Next state is IDLE.
- **`stall_o`** = (IDLE & accept condition) | REQ.
- **Loads** (funct3):
  - 000 LB, 100 LBU: 1 byte.
  - 001 LH, 101 LHU: 2 bytes.
  - 010 LW, 110 LWU: 4 bytes.
  - 011 LD: 8 bytes.
  - 111: illegal.
- **Load data path**: shift `dmem_rdata_i` right by addr[2:0]×8, then truncate to the access size.
  - Signed loads sign-extend from the top bit of the access.
  - Unsigned loads zero-extend.
  - LD returns the word unmodified.
- **Stores** (funct3): 000 SB, 001 SH, 010 SW, 011 SD; 1xx illegal.
- **Store mask and data**:
  - Mask = {01, 03, 0F, FF} << addr[2:0].
  - Data = `wdata_i` << addr[2:0]×8.
  - Loads drive mask 00.
- **Errors** (error path: DONE with `err_o`=1, `rdata_o`=0, no memory activity):
  - Misalignment: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Illegal funct3.
  - `mem_read_i` and `mem_write_i` both high.
- **Stores** complete with `rdata_o`=0.
- **`rdata_o`** holds its last value except on `done_o`, where it updates.

## Timing
- Reset values: state IDLE; all outputs 0, including `stall_o` unless the accept condition is present (it is combinational).
- Legal access, ack in the first REQ cycle:
  - T0: accept, `stall_o`=1.
  - T1: `dmem_req_o`=1, ack.
  - T2: `done_o`=1.
  - 3 cycles minimum; each extra wait cycle adds 1.
- Illegal access: T0 accept, T1 DONE; 2 cycles total.
- `dmem_req_o` is registered and never glitches. It deasserts in the cycle after ack is sampled.
- Back-to-back accesses: the next instruction is presented after DONE and is accepted in the following IDLE cycle. There is no bubble beyond the DONE→IDLE cycle.
- Reset asserted mid-operation:
  - Immediately go to IDLE; `dmem_req_o`, `done_o` and `err_o` drop asynchronously.
  - The outstanding memory transaction is abandoned.
  - A late ack after reset is ignored.
- `dmem_ack_i` while `dmem_req_o`=0 is ignored.

## Test plan
- **LB**: addr=0x1003, rdata_i=0x0000_0000_80FF_0000, ack after 2 wait cycles → `dmem_addr_o`=0x1000, `stall_o` high 4 cycles, `done_o` at T4, `rdata_o`=0xFFFF_FFFF_FFFF_FF80.
- **LWU / LW**: addr=0x2004, rdata_i=0x8765_4321_0000_0000, immediate ack.
  - LWU → `rdata_o`=0x0000_0000_8765_4321, `done_o` at T2.
  - LW → `rdata_o`=0xFFFF_FFFF_8765_4321.
- **SH**: addr=0x3006, wdata=0x1234 → `dmem_we_o`=1, `dmem_wmask_o`=0xC0, `dmem_wdata_o`=0x1234_0000_0000_0000. Req stays stable until ack, then `done_o`, `rdata_o`=0.
- **Misaligned SW**: addr=0x4002 → `dmem_req_o` never asserts, `done_o`=`err_o`=1 at T1, `stall_o` high 1 cycle.
- **Abandoned transaction**: `rstn` pulled low during REQ, then ack arrives after release → outputs 0 at once, state IDLE, no `done_o`.
- **Back-to-back**: SD 0x5000 then LD 0x5000, memory model echoing data → second access accepted on the cycle after the first DONE, `rdata_o`=stored value.
